// File: rtl/bp_me_wormhole_packet_serializer.sv
// Wormhole packet serializer: assembles {data, msg_hdr, cid, len, cord} from one
// accepted message and streams it onto the link one flit per cycle.
module bp_me_wormhole_packet_serializer #(
  parameter int flit_width_p     = 64,
  parameter int cord_width_p     = 7,
  parameter int len_width_p      = 4,
  parameter int cid_width_p      = 2,
  parameter int msg_hdr_width_p  = 51,
  parameter int max_data_bytes_p = 64
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [msg_hdr_width_p-1:0]        msg_hdr_i,
  input  logic [cord_width_p-1:0]           dst_cord_i,
  input  logic [cid_width_p-1:0]            dst_cid_i,
  input  logic                              has_data_i,
  input  logic [$clog2(max_data_bytes_p):0] size_i,
  input  logic [8*max_data_bytes_p-1:0]     data_i,
  input  logic                              v_i,
  output logic                              ready_and_o,
  output logic [flit_width_p-1:0]           link_data_o,
  output logic                              link_v_o,
  input  logic                              link_ready_and_i
);

  localparam int lg_max_lp       = $clog2(max_data_bytes_p);
  localparam int size_width_lp   = lg_max_lp + 1;
  localparam int wh_hdr_width_lp = cord_width_p + len_width_p + cid_width_p + msg_hdr_width_p;
  localparam int data_width_lp   = 8 * max_data_bytes_p;
  localparam int max_flits_lp    = (wh_hdr_width_lp + data_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int pkt_width_lp    = max_flits_lp * flit_width_p;

  if ((max_flits_lp - 1) >= (1 << len_width_p)) begin : g_len_check
    $error("len_width_p too small for the largest packet");
  end
  if ((1 << lg_max_lp) != max_data_bytes_p) begin : g_pow2_check
    $error("max_data_bytes_p must be a power of two");
  end

  // Flit count minus one for a payload of nbytes; folds to a constant per size.
  function automatic logic [len_width_p-1:0] len_for_bytes(input int nbytes);
    int nflits;
    nflits = (wh_hdr_width_lp + 8 * nbytes + flit_width_p - 1) / flit_width_p;
    return len_width_p'(nflits - 1);
  endfunction

  typedef enum logic [0:0] {e_ready, e_send} state_e;

  state_e                   state_r, state_n;
  logic [len_width_p-1:0]   count_r, len_r, len_sel;
  logic [pkt_width_lp-1:0]  pkt_r, pkt_new;
  logic [data_width_lp-1:0] data_masked;
  logic                     accept, last_flit;
  int                       nbytes;

  always_comb begin
    nbytes  = max_data_bytes_p;
    len_sel = len_for_bytes(max_data_bytes_p);
    if (!has_data_i) begin
      nbytes  = 0;
      len_sel = len_for_bytes(0);
    end else begin
      for (int s = 0; s <= lg_max_lp; s++) begin
        if (size_i == size_width_lp'(s)) begin
          nbytes  = 1 << s;
          len_sel = len_for_bytes(1 << s);
        end
      end
    end
  end

  always_comb begin
    data_masked = '0;
    for (int i = 0; i < max_data_bytes_p; i++) begin
      data_masked[8*i +: 8] = (i < nbytes) ? data_i[8*i +: 8] : 8'h00;
    end
    pkt_new = '0;
    pkt_new[wh_hdr_width_lp+data_width_lp-1:0] =
      {data_masked, msg_hdr_i, dst_cid_i, len_sel, dst_cord_i};
  end

  assign last_flit   = (count_r == len_r);
  assign accept      = v_i & ready_and_o;
  assign link_data_o = pkt_r[flit_width_p-1:0];

  always_comb begin
    state_n     = state_r;
    ready_and_o = 1'b0;
    link_v_o    = 1'b0;
    case (state_r)
      e_ready: begin
        ready_and_o = 1'b1;
        if (v_i) state_n = e_send;
      end
      e_send: begin
        link_v_o = 1'b1;
        if (link_ready_and_i && last_flit) begin
          ready_and_o = 1'b1;
          state_n     = v_i ? e_send : e_ready;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  // The packet is held in a shift register so the current flit is always the LSBs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_r   <= '0;
      count_r <= '0;
      len_r   <= '0;
    end else if (accept) begin
      pkt_r   <= pkt_new;
      count_r <= '0;
      len_r   <= len_sel;
    end else if (state_r == e_send && link_ready_and_i) begin
      pkt_r   <= pkt_r >> flit_width_p;
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_packet_serializer.sv
// Scoreboard bench for bp_me_wormhole_packet_serializer with default parameters.
module tb_bp_me_wormhole_packet_serializer;

  logic         clk = 0;
  logic         reset_i = 1;
  logic [50:0]  msg_hdr_i = '0;
  logic [6:0]   dst_cord_i = '0;
  logic [1:0]   dst_cid_i = '0;
  logic         has_data_i = 0;
  logic [6:0]   size_i = '0;
  logic [511:0] data_i = '0;
  logic         v_i = 0;
  logic         ready_and_o;
  logic [63:0]  link_data_o;
  logic         link_v_o;
  logic         link_ready_and_i = 0;

  bp_me_wormhole_packet_serializer dut (
    .clk_i(clk), .reset_i(reset_i), .msg_hdr_i(msg_hdr_i), .dst_cord_i(dst_cord_i),
    .dst_cid_i(dst_cid_i), .has_data_i(has_data_i), .size_i(size_i), .data_i(data_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .link_data_o(link_data_o), .link_v_o(link_v_o),
    .link_ready_and_i(link_ready_and_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] flit; logic last;} exp_t;
  exp_t        q[$];
  logic [63:0] seen[$];
  int          pop_cycles[$];
  int          cyc = 0;
  int          total_cnt = 0;
  int          pass_cnt = 0;
  int          link_mode = 0;
  int          acc_cycle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: packet built field by field from the message, then cut into 64b flits.
  task automatic push_expected(input logic [50:0] hdr, input logic [6:0] cord, input logic [1:0] cid,
                               input logic has, input logic [6:0] size, input logic [511:0] data);
    logic [575:0] pkt;
    int nbytes, nflits;
    nbytes = has ? ((size > 6) ? 64 : (1 << size)) : 0;
    nflits = (64 + 8 * nbytes + 63) / 64;
    pkt = '0;
    pkt[6:0]   = cord;
    pkt[10:7]  = 4'(nflits - 1);
    pkt[12:11] = cid;
    pkt[63:13] = hdr;
    for (int i = 0; i < nbytes; i++) pkt[64 + 8*i +: 8] = data[8*i +: 8];
    for (int k = 0; k < nflits; k++) q.push_back({pkt[64*k +: 64], k == nflits - 1});
  endtask

  always begin
    @(posedge clk); #1;
    case (link_mode)
      0: link_ready_and_i = ($urandom_range(0, 3) != 0);
      1: link_ready_and_i = 1'b1;
      default: link_ready_and_i = ~link_ready_and_i;
    endcase
  end

  // Monitor: every presented flit must match the scoreboard head and stay put until taken.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_i) begin
      if (link_v_o) begin
        if (q.size() == 0) fail("unexpected_flit");
        else begin
          e = q[0];
          check("flit_data", link_data_o, e.flit);
          check("ready_while_send", {63'b0, ready_and_o}, {63'b0, link_ready_and_i & e.last});
          if (link_ready_and_i) begin
            void'(q.pop_front());
            seen.push_back(link_data_o);
            pop_cycles.push_back(cyc);
          end
        end
      end else begin
        check("ready_idle", {63'b0, ready_and_o}, 64'd1);
      end
    end
  end

  task automatic send_msg(input logic [50:0] hdr, input logic [6:0] cord, input logic [1:0] cid,
                          input logic has, input logic [6:0] size, input logic [511:0] data);
    bit ok;
    @(posedge clk); #1;
    msg_hdr_i = hdr; dst_cord_i = cord; dst_cid_i = cid;
    has_data_i = has; size_i = size; data_i = data; v_i = 1'b1;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ready_and_o) begin
        push_expected(hdr, cord, cid, has, size, data);
        acc_cycle = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) fail("accept_timeout");
  endtask

  task automatic idle();
    @(posedge clk); #1;
    v_i = 1'b0;
    msg_hdr_i = 51'($urandom); data_i = '1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      if (q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) fail("drain_timeout");
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [511:0] inc;
    int a0;
    bit ok;
    for (int i = 0; i < 64; i++) inc[8*i +: 8] = 8'(i + 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'b0, ready_and_o}, 64'd1);
    check("reset_link_v", {63'b0, link_v_o}, 64'd0);
    check("reset_link_data", link_data_o, 64'd0);
    @(posedge clk); #1;
    reset_i = 0;
    link_mode = 1;

    seen.delete(); pop_cycles.delete();
    send_msg(51'h5A5, 7'h12, 2'h1, 1'b0, 7'd0, rand_data());
    a0 = acc_cycle;
    idle(); drain();
    check("nodata_flits", 64'(seen.size()), 64'd1);
    if (seen.size() >= 1) check("nodata_flit0", seen[0], {51'h5A5, 2'h1, 4'h0, 7'h12});
    if (pop_cycles.size() >= 1) check("nodata_latency", 64'(pop_cycles[0]), 64'(a0 + 1));

    seen.delete();
    send_msg(51'h1234, 7'h05, 2'h2, 1'b1, 7'd0, {504'h0, 8'hAB} | {rand_data()} & ~512'hFF);
    idle(); drain();
    check("byte1_flits", 64'(seen.size()), 64'd2);
    if (seen.size() >= 2) begin
      check("byte1_len", 64'(seen[0][10:7]), 64'd1);
      check("byte1_flit1", seen[1], 64'h00000000000000AB);
    end

    link_mode = 2;
    seen.delete();
    send_msg(51'h7_0000_0000_0001, 7'h7F, 2'h3, 1'b1, 7'd6, inc);
    idle(); drain();
    check("full_flits", 64'(seen.size()), 64'd9);
    if (seen.size() >= 9) begin
      check("full_len", 64'(seen[0][10:7]), 64'd8);
      check("full_flit8", seen[8], 64'h403F3E3D3C3B3A39);
    end

    link_mode = 1;
    seen.delete(); pop_cycles.delete();
    send_msg(51'h11, 7'h01, 2'h0, 1'b1, 7'd3, rand_data());
    a0 = acc_cycle;
    send_msg(51'h22, 7'h02, 2'h1, 1'b1, 7'd3, rand_data());
    check("b2b_second_accept", 64'(acc_cycle), 64'(a0 + 2));
    idle(); drain();
    check("b2b_flits", 64'(seen.size()), 64'd4);
    if (pop_cycles.size() >= 4) begin
      check("b2b_first_latency", 64'(pop_cycles[0]), 64'(a0 + 1));
      check("b2b_no_bubble", 64'(pop_cycles[3] - pop_cycles[0]), 64'd3);
    end

    seen.delete();
    send_msg(51'h33, 7'h03, 2'h2, 1'b1, 7'd7, rand_data());
    idle(); drain();
    check("clamp_flits", 64'(seen.size()), 64'd9);
    if (seen.size() >= 1) check("clamp_len", 64'(seen[0][10:7]), 64'd8);
    seen.delete();
    send_msg(51'h44, 7'h04, 2'h3, 1'b0, 7'd6, rand_data());
    idle(); drain();
    check("nodata_size6_flits", 64'(seen.size()), 64'd1);
    if (seen.size() >= 1) check("nodata_size6_len", 64'(seen[0][10:7]), 64'd0);

    seen.delete();
    send_msg(51'h55, 7'h06, 2'h0, 1'b1, 7'd6, inc);
    idle();
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (seen.size() >= 3) begin ok = 1; break; end
    end
    if (!ok) fail("reset_wait_timeout");
    @(posedge clk); #1;
    reset_i = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("reset_mid_link_v", {63'b0, link_v_o}, 64'd0);
    check("reset_mid_ready", {63'b0, ready_and_o}, 64'd1);
    check("reset_mid_partial", 64'(seen.size()), 64'd3);
    seen.delete();
    send_msg(51'h66, 7'h08, 2'h1, 1'b0, 7'd2, rand_data());
    idle(); drain();
    check("post_reset_flits", 64'(seen.size()), 64'd1);
    if (seen.size() >= 1) check("post_reset_len", 64'(seen[0][10:7]), 64'd0);

    link_mode = 0;
    for (int m = 0; m < 150; m++) begin
      send_msg(51'({$urandom, $urandom}), 7'($urandom), 2'($urandom), 1'($urandom),
               7'($urandom_range(0, 7)), rand_data());
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    idle();
    link_mode = 1;
    drain();
    check("final_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bp_me_wormhole_packet_serializer.md
# bp_me_wormhole_packet_serializer

Parametrised coherence/memory NoC packet serializer. It accepts one message per handshake: a message header, a destination cord/cid, and an optional power-of-two-sized data payload. It computes the wormhole length field, assembles the packet {data, msg_hdr, cid, len, cord}, and streams it one flit per cycle onto a wormhole link. It sits between an LCE/CCE message source and the wormhole router adapter. It supersedes per-message-class combinational header encoders by handling any header width and payload size, including the serialization.

## Interface
Parameters:
- flit_width_p, 64: link flit width in bits.
- cord_width_p, 7: destination coordinate width.
- len_width_p, 4: wormhole length field width.
- cid_width_p, 2: concentrator id width.
- msg_hdr_width_p, 51: message header width.
- max_data_bytes_p, 64: largest payload in bytes; must be a power of two.
- Derived: wh_hdr_width = cord_width_p + len_width_p + cid_width_p + msg_hdr_width_p.
- Derived: max_flits = ceil((wh_hdr_width + 8*max_data_bytes_p) / flit_width_p). Elaboration fails if max_flits-1 does not fit in len_width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- msg_hdr_i  in  msg_hdr_width_p  message header, opaque.
- dst_cord_i  in  cord_width_p  destination router coordinate.
- dst_cid_i  in  cid_width_p  destination concentrator id.
- has_data_i  in  1  message carries a payload.
- size_i  in  log2(max_data_bytes_p)+1  payload is 2^size_i bytes. Ignored when has_data_i=0.
- data_i  in  8*max_data_bytes_p  payload; byte 0 is in the LSBs.
- v_i  in  1  input message valid.
- ready_and_o  out  1  block accepts the message this cycle.
- link_data_o  out  flit_width_p  current flit.
- link_v_o  out  1  flit valid.
- link_ready_and_i  in  1  link consumes the flit this cycle.

## Operation
- Byte count: nbytes = has_data_i ? min(2^size_i, max_data_bytes_p) : 0. Sizes above the maximum clamp to max_data_bytes_p.
- Length: len = ceil((wh_hdr_width + 8*nbytes) / flit_width_p) - 1. This is a constant per size, precomputed as localparams, and selected by a case on the size.
- Packet bit layout, LSB first:
  - cord at [cord_width_p-1:0]
  - then len
  - then cid
  - then msg_hdr
  - then data.
- Data bytes at index nbytes and above are forced to zero. Bits past the packet end in the last flit are zero.
- Flit k = packet[k*flit_width_p +: flit_width_p], for k = 0..len.
- Accept: v_i & ready_and_o. On accept the block registers the assembled packet (or a shift register) and len, and clears the flit counter.
- FSM:
  - e_ready: link_v_o=0, ready_and_o=1. On accept, go to e_send.
  - e_send: link_v_o=1, and link_data_o is flit[count]. On link_ready_and_i, count increments. On the handshake of flit len:
    - if v_i is also high, accept the next message, stay in e_send, and reset count to 0;
    - otherwise go to e_ready.
- ready_and_o = (state==e_ready) | (state==e_send & count==len & link_ready_and_i). This is a combinational path from link_ready_and_i to ready_and_o.
- link_data_o and len are stable while link_v_o=1 and link_ready_and_i=0.
- Inputs are sampled only on the accept cycle. Later changes to them have no effect.

## Timing
- Reset values:
  - state=e_ready, count=0, link_v_o=0, ready_and_o=1 (combinational, during and after reset release).
  - link_data_o is don't-care and is zeroed on reset.
- Latency: flit 0 is valid the cycle after accept. An N-flit packet with link_ready_and_i held high occupies N consecutive cycles.
- Back-to-back: the next packet's flit 0 follows the previous packet's last flit with zero bubble.
- Backpressure: with link_ready_and_i low, the current flit is held indefinitely and no message is accepted.
- Reset asserted mid-packet: the packet is discarded and link_v_o=0 the following cycle. No partial flits are emitted afterward.
- A single-flit packet (len=0) accepted back-to-back achieves one packet per cycle.

## Test plan
- No data, defaults (wh_hdr 64b): msg_hdr=51'h5A5, cord=7'h12, cid=2'h1 -> one flit, len=0, link_data_o={51'h5A5, 2'h1, 4'h0, 7'h12}, one cycle after accept.
- has_data=1, size=0 (1B), data byte0=8'hAB -> len=1, 2 flits. Flit1 = 64'h00000000000000AB.
- size=6 (64B), incrementing bytes, link_ready_and_i toggled 1010... -> len=8, 9 flits in order. Each flit is held while not ready. ready_and_o stays low until flit 8 is consumed.
- Two 8B packets with v_i held high and link ready high -> 4 flits in 4 consecutive cycles with no bubble. The second packet is accepted exactly on the cycle flit 1 of the first is consumed.
- has_data=1, size=7 (128B > max) -> clamped to 64B, len=8. has_data=0 with size=6 -> len=0.
- Assert reset_i during flit 3 of a 9-flit packet -> link_v_o=0 the next cycle, and ready_and_o=1. A new no-data packet then sends correctly with len=0.
